vstore_sequencer: RTL and testbench
===================================

VSTORE_SEQUENCER -- requirements
Module: vstore_sequencer

Interface
REQ-001 Parameter AddrWidth, default 32: memory byte-address width.
REQ-002 Parameter MaxOutstanding, default 4: maximum accepted memory writes awaiting response.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i/req_ready_o  in/out  1/1  store command handshake.
REQ-006 req_insn_id_i  input  insn_id_t  instruction id of command.
REQ-007 req_base_addr_i  input  AddrWidth  start byte address.
REQ-008 req_vlB_i  input  vlen_t  total bytes to store.
REQ-009 op_valid_i/op_gnt_o  in/out  1/1  store operand beat handshake (valid/gnt).
REQ-010 op_i  input  vrf_data_t  operand beat.
REQ-011 mem_req_valid_o/mem_req_ready_i  out/in  1/1  memory write handshake.
REQ-012 mem_addr_o  output  AddrWidth  beat address; mem_wdata_o output vrf_data_t; mem_strb_o output VRFWordWidthB byte strobes.
REQ-013 mem_rsp_valid_i  input  1  one write response; mem_rsp_err_i input 1 response error flag.
REQ-014 done_o/done_gnt_i  out/in  1/1  completion handshake; done_insn_id_o insn_id_t; done_err_o 1.

Function
REQ-015 States IDLE, ISSUE, DRAIN, DONE; the sequencer SHALL hold one command at a time.
REQ-016 req_ready_o SHALL be 1 only in IDLE; command captured on req_valid_i&&req_ready_o; next state ISSUE, or DONE if req_vlB_i==0.
REQ-017 Base address SHALL be word-aligned by forcing low log2(VRFWordWidthB) bits to zero on capture.
REQ-018 In ISSUE: mem_req_valid_o = op_valid_i && (out_cnt_q < MaxOutstanding); mem_wdata_o = op_i combinationally; op_gnt_o = mem_req_valid_o && mem_req_ready_i (same cycle, zero latency).
REQ-019 On accepted beat: address += VRFWordWidthB, remaining bytes -= VRFWordWidthB, out_cnt +1.
REQ-020 mem_strb_o SHALL be all ones when remaining >= VRFWordWidthB, else low `remaining` bits set.
REQ-021 Accepted beat with remaining <= VRFWordWidthB is last; next state DRAIN.
REQ-022 mem_rsp_valid_i decrements out_cnt; simultaneous accept and response leaves it unchanged; response with out_cnt_q==0 SHALL be ignored.
REQ-023 Error flag SHALL be sticky OR of mem_rsp_err_i over counted responses of the current command; cleared on command capture.
REQ-024 DRAIN -> DONE when out_cnt_q==0.
REQ-025 DONE: done_o=1, done_insn_id_o/done_err_o from captured command; on done_gnt_i -> IDLE; done_o held until granted.
REQ-026 All outputs SHALL be stable while valid and not granted (mem request and done).
REQ-027 Earliest first memory request SHALL be the cycle after command capture.
REQ-028 out_cnt width SHALL be $clog2(MaxOutstanding+1); never exceeds MaxOutstanding.

Reset
REQ-029 rst_i SHALL force IDLE, out_cnt=0, error=0; outputs req_ready_o=1, mem_req_valid_o=0, op_gnt_o=0, done_o=0, done_err_o=0 in the cycle following.
REQ-030 Reset mid-command SHALL abandon it without done; later responses to abandoned writes are ignored per REQ-022.
REQ-031 Captured address/id/length registers need no reset.

Structure
REQ-032 insn_id_t, vlen_t, vrf_data_t, VRFWordWidthB SHALL come from core_pkg; sequencer state enum local to the module.
REQ-033 No sub-module required; strobe generation may be a local function.

Verification (VRFWordWidthB=8)
REQ-034 Command addr 0x100, vlB 24, operands always valid, mem ready -> 3 beats at 0x100/0x108/0x110, strb 0xFF, done after 3 responses.
REQ-035 vlB 13 -> beats strb 0xFF then 0x1F, then DRAIN, then DONE.
REQ-036 MaxOutstanding=4, no responses, vlB 64 -> exactly 4 beats issued, mem_req_valid_o low until a response arrives.
REQ-037 vlB 0 -> no memory request, done_o the cycle after capture; done_gnt_i held low 5 cycles -> done_o stays 1.
REQ-038 One response with err=1 among 3 -> done_err_o=1; next command done_err_o=0.
REQ-039 rst_i asserted in ISSUE after 2 of 4 beats -> IDLE, no done_o; new command completes normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: instruction ids, vector lengths and VRF word data.
// Pure type/constant package, no logic.
// No flow control of its own.
package core_pkg;

   localparam int unsigned VRFWordWidthB = 8;

   typedef logic [3:0]                   insn_id_t;
   typedef logic [15:0]                  vlen_t;
   typedef logic [8*VRFWordWidthB-1:0]   vrf_data_t;

endpackage

// File: rtl/vstore_sequencer_pkg.sv
// Helpers for the vector store sequencer: beat size constants and strobe builder.
// Pure combinational helpers, no latency.
// No flow control of its own.
package vstore_sequencer_pkg;

   import core_pkg::*;

   localparam int unsigned WordOffW  = $clog2(VRFWordWidthB);
   localparam vlen_t       BeatBytes = vlen_t'(VRFWordWidthB);

   typedef logic [VRFWordWidthB-1:0] strb_t;

   // Byte i is written when it lies below the remaining byte count, which
   // yields all ones for any full beat and a low-aligned mask for the tail.
   function automatic strb_t beat_strb(input vlen_t remaining);
      strb_t s;
      s = '0;
      for (int i = 0; i < VRFWordWidthB; i++) begin
         s[i] = (vlen_t'(i) < remaining);
      end
      return s;
   endfunction

endpackage

// File: rtl/vstore_sequencer_if.sv
// Bundle of command, operand, memory-write and completion handshakes.
// Wires only, no latency.
// Each channel carries its own valid/ready (or valid/gnt) pair.
interface vstore_sequencer_if
   import core_pkg::*, vstore_sequencer_pkg::*;
#(
   parameter int unsigned AddrWidth = 32
);
   // store command
   logic                 req_valid_i;
   logic                 req_ready_o;
   insn_id_t             req_insn_id_i;
   logic [AddrWidth-1:0] req_base_addr_i;
   vlen_t                req_vlB_i;
   // operand beats
   logic                 op_valid_i;
   logic                 op_gnt_o;
   vrf_data_t            op_i;
   // memory writes and responses
   logic                 mem_req_valid_o;
   logic                 mem_req_ready_i;
   logic [AddrWidth-1:0] mem_addr_o;
   vrf_data_t            mem_wdata_o;
   strb_t                mem_strb_o;
   logic                 mem_rsp_valid_i;
   logic                 mem_rsp_err_i;
   // completion
   logic                 done_o;
   logic                 done_gnt_i;
   insn_id_t             done_insn_id_o;
   logic                 done_err_o;

   // sequencer side
   modport slave (
      input  req_valid_i, req_insn_id_i, req_base_addr_i, req_vlB_i,
      output req_ready_o,
      input  op_valid_i, op_i,
      output op_gnt_o,
      output mem_req_valid_o, mem_addr_o, mem_wdata_o, mem_strb_o,
      input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_err_i,
      output done_o, done_insn_id_o, done_err_o,
      input  done_gnt_i
   );

   // environment side
   modport master (
      output req_valid_i, req_insn_id_i, req_base_addr_i, req_vlB_i,
      input  req_ready_o,
      output op_valid_i, op_i,
      input  op_gnt_o,
      input  mem_req_valid_o, mem_addr_o, mem_wdata_o, mem_strb_o,
      output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_err_i,
      input  done_o, done_insn_id_o, done_err_o,
      output done_gnt_i
   );

endinterface

// File: rtl/vstore_sequencer.sv
// Vector store sequencer: splits one store command into word-sized memory writes.
// Operand-to-memory path is zero latency; first write the cycle after capture.
// Writes stall on operand/memory backpressure or MaxOutstanding; done held until granted.
module vstore_sequencer
   import core_pkg::*, vstore_sequencer_pkg::*;
#(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned MaxOutstanding = 4
) (
   input logic          clk_i,
   input logic          rst_i,
   vstore_sequencer_if.slave bus
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q;
   vlen_t                rem_q;
   insn_id_t             id_q;
   logic                 err_q;
   logic [CntW-1:0]      out_cnt_q;

   logic req_ready, mem_req_valid, op_gnt, done;
   logic capture, beat_acc, rsp_cnt, can_issue, last_beat;

   assign capture   = bus.req_valid_i && req_ready;
   assign beat_acc  = op_gnt;
   // a response with nothing outstanding belongs to an abandoned command
   assign rsp_cnt   = bus.mem_rsp_valid_i && (out_cnt_q != '0);
   assign can_issue = out_cnt_q < CntW'(MaxOutstanding);
   assign last_beat = rem_q <= BeatBytes;

   // Next-state and handshake outputs.
   always_comb begin
      state_d       = state_q;
      req_ready     = 1'b0;
      mem_req_valid = 1'b0;
      op_gnt        = 1'b0;
      done          = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid_i) begin
               state_d = (bus.req_vlB_i == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            mem_req_valid = bus.op_valid_i && can_issue;
            op_gnt        = mem_req_valid && bus.mem_req_ready_i;
            if (op_gnt && last_beat) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (bus.done_gnt_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, outstanding counter and sticky error flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         out_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (beat_acc && !rsp_cnt) begin
            out_cnt_q <= out_cnt_q + 1'b1;
         end else if (!beat_acc && rsp_cnt) begin
            out_cnt_q <= out_cnt_q - 1'b1;
         end
         if (capture) begin
            err_q <= 1'b0;
         end else if (rsp_cnt) begin
            err_q <= err_q | bus.mem_rsp_err_i;
         end
      end
   end

   // Command registers: word-aligned address, remaining bytes and id.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         addr_q <= {bus.req_base_addr_i[AddrWidth-1:WordOffW], {WordOffW{1'b0}}};
         rem_q  <= bus.req_vlB_i;
         id_q   <= bus.req_insn_id_i;
      end else if (beat_acc) begin
         addr_q <= addr_q + AddrWidth'(VRFWordWidthB);
         rem_q  <= last_beat ? '0 : rem_q - BeatBytes;
      end
   end

   assign bus.req_ready_o     = req_ready;
   assign bus.mem_req_valid_o = mem_req_valid;
   assign bus.op_gnt_o        = op_gnt;
   assign bus.mem_addr_o      = addr_q;
   assign bus.mem_wdata_o     = bus.op_i;
   assign bus.mem_strb_o      = beat_strb(rem_q);
   assign bus.done_o          = done;
   assign bus.done_insn_id_o  = id_q;
   assign bus.done_err_o      = err_q;

endmodule

// File: tb/tb_vstore_sequencer.sv
// Directed bench for vstore_sequencer: command table plus corner-case sequences.
// Inputs change 1 time unit after the rising edge; outputs are read before the next edge.
// Memory responses come from a simple in-order responder that can be paused.
module tb_vstore_sequencer;
   import core_pkg::*;

   localparam int unsigned AW = 32;
   localparam vrf_data_t DATA_BASE = 64'hA5A5_0000_0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vstore_sequencer_if #(.AddrWidth(AW)) bus();

   vstore_sequencer #(.AddrWidth(AW), .MaxOutstanding(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int beats = 0;
   int rsps  = 0;
   bit rsp_en = 1'b0;
   bit stale_rsp = 1'b0;
   logic [7:0] err_mask = 8'h00;
   logic [AW-1:0] rec_addr [64];
   logic [7:0]    rec_strb [64];
   vrf_data_t     rec_data [64];

   typedef struct {
      logic [31:0] addr;
      vlen_t       vlb;
      insn_id_t    id;
      logic [7:0]  mask;
      int          exp_beats;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
      logic [7:0]  exp_lstrb;
      logic        exp_err;
   } vec_t;
   vec_t tbl [7];

   // record accepted beats and responses sent
   always @(negedge clk) begin
      if (bus.mem_req_valid_o && bus.mem_req_ready_i && beats < 64) begin
         rec_addr[beats] = bus.mem_addr_o;
         rec_strb[beats] = bus.mem_strb_o;
         rec_data[beats] = bus.mem_wdata_o;
         beats++;
      end
      if (bus.mem_rsp_valid_i) rsps++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (stale_rsp) begin
         bus.mem_rsp_valid_i = 1'b1;
         bus.mem_rsp_err_i   = 1'b1;
      end else if (rsp_en && beats > rsps) begin
         bus.mem_rsp_valid_i = 1'b1;
         bus.mem_rsp_err_i   = err_mask[rsps % 8];
      end else begin
         bus.mem_rsp_valid_i = 1'b0;
         bus.mem_rsp_err_i   = 1'b0;
      end
      bus.op_i = DATA_BASE + vrf_data_t'(beats);
      #1;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (bus.done_o) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic grant_done();
      bus.done_gnt_i = 1'b1;
      tick();
      bus.done_gnt_i = 1'b0;
      bus.op_valid_i = 1'b0;
   endtask

   task automatic start_cmd(input logic [31:0] addr, input vlen_t vlb, input insn_id_t id);
      beats = 0;
      rsps  = 0;
      bus.req_base_addr_i = addr;
      bus.req_vlB_i       = vlb;
      bus.req_insn_id_i   = id;
      bus.req_valid_i     = 1'b1;
      bus.op_valid_i      = 1'b1;
   endtask

   task automatic run_cmd(input logic [31:0] addr, input vlen_t vlb, input insn_id_t id,
                          input logic [7:0] mask, output bit seen, output logic derr,
                          output insn_id_t did, output bit rsp_ok);
      err_mask = mask;
      rsp_en   = 1'b1;
      start_cmd(addr, vlb, id);
      bus.mem_req_ready_i = 1'b1;
      tick();
      bus.req_valid_i = 1'b0;
      wait_done(seen);
      derr   = bus.done_err_o;
      did    = bus.done_insn_id_o;
      rsp_ok = (rsps == beats);
      grant_done();
   endtask

   initial begin
      bit seen, rsp_ok;
      logic derr;
      insn_id_t did;
      int bad, drops;

      tbl[0] = '{32'h100, 16'd24, 4'd1, 8'h00, 3, 32'h100, 32'h110, 8'hFF, 1'b0};
      tbl[1] = '{32'h200, 16'd13, 4'd2, 8'h00, 2, 32'h200, 32'h208, 8'h1F, 1'b0};
      tbl[2] = '{32'h305, 16'd8,  4'd3, 8'h00, 1, 32'h300, 32'h300, 8'hFF, 1'b0};
      tbl[3] = '{32'h400, 16'd24, 4'd4, 8'h02, 3, 32'h400, 32'h410, 8'hFF, 1'b1};
      tbl[4] = '{32'h500, 16'd9,  4'd5, 8'h00, 2, 32'h500, 32'h508, 8'h01, 1'b0};
      tbl[5] = '{32'h600, 16'd1,  4'd6, 8'h00, 1, 32'h600, 32'h600, 8'h01, 1'b0};
      tbl[6] = '{32'h700, 16'd0,  4'd14, 8'h00, 0, 32'h0, 32'h0, 8'h00, 1'b0};

      bus.req_valid_i = 1'b0;  bus.req_insn_id_i = '0; bus.req_base_addr_i = '0;
      bus.req_vlB_i = '0;      bus.op_valid_i = 1'b0;  bus.op_i = '0;
      bus.mem_req_ready_i = 1'b0; bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_err_i = 1'b0;
      bus.done_gnt_i = 1'b0;

      // reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
      check("rst_mem_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
      check("rst_op_gnt", 64'(bus.op_gnt_o), 64'd0);
      check("rst_done", 64'(bus.done_o), 64'd0);
      check("rst_done_err", 64'(bus.done_err_o), 64'd0);

      // table of complete commands with an always-ready memory
      foreach (tbl[v]) begin
         run_cmd(tbl[v].addr, tbl[v].vlb, tbl[v].id, tbl[v].mask, seen, derr, did, rsp_ok);
         check($sformatf("v%0d_done_seen", v), 64'(seen), 64'd1);
         check($sformatf("v%0d_beats", v), 64'(beats), 64'(tbl[v].exp_beats));
         check($sformatf("v%0d_done_id", v), 64'(did), 64'(tbl[v].id));
         check($sformatf("v%0d_done_err", v), 64'(derr), 64'(tbl[v].exp_err));
         check($sformatf("v%0d_all_rsp_before_done", v), 64'(rsp_ok), 64'd1);
         if (tbl[v].exp_beats > 0) begin
            check($sformatf("v%0d_first_addr", v), 64'(rec_addr[0]), 64'(tbl[v].exp_first));
            check($sformatf("v%0d_last_addr", v), 64'(rec_addr[tbl[v].exp_beats-1]), 64'(tbl[v].exp_last));
            check($sformatf("v%0d_last_strb", v), 64'(rec_strb[tbl[v].exp_beats-1]), 64'(tbl[v].exp_lstrb));
            bad = 0;
            for (int k = 0; k < tbl[v].exp_beats - 1; k++) if (rec_strb[k] !== 8'hFF) bad++;
            for (int k = 0; k < tbl[v].exp_beats; k++) if (rec_data[k] !== DATA_BASE + vrf_data_t'(k)) bad++;
            check($sformatf("v%0d_body_strb_data", v), 64'(bad), 64'd0);
         end
      end

      // outstanding limit: no responses, 64 bytes -> only 4 beats go out
      rsp_en = 1'b0;
      err_mask = 8'h00;
      start_cmd(32'h800, 16'd64, 4'd9);
      bus.mem_req_ready_i = 1'b1;
      tick();
      bus.req_valid_i = 1'b0;
      repeat (10) tick();
      check("limit_beats", 64'(beats), 64'd4);
      check("limit_req_valid_low", 64'(bus.mem_req_valid_o), 64'd0);
      rsp_en = 1'b1;
      wait_done(seen);
      check("limit_done_seen", 64'(seen), 64'd1);
      check("limit_total_beats", 64'(beats), 64'd8);
      grant_done();

      // zero-length command and done held without grant
      start_cmd(32'h880, 16'd0, 4'd10);
      tick();
      bus.req_valid_i = 1'b0;
      check("zero_done_next_cycle", 64'(bus.done_o), 64'd1);
      drops = 0;
      repeat (5) begin
         tick();
         if (bus.done_o !== 1'b1) drops++;
      end
      check("zero_done_held", 64'(drops), 64'd0);
      check("zero_no_beats", 64'(beats), 64'd0);
      check("zero_done_id", 64'(bus.done_insn_id_o), 64'd10);
      grant_done();

      // first request timing and stability under memory stall
      start_cmd(32'h900, 16'd16, 4'd11);
      bus.mem_req_ready_i = 1'b0;
      #1;
      check("no_req_in_capture_cycle", 64'(bus.mem_req_valid_o), 64'd0);
      tick();
      bus.req_valid_i = 1'b0;
      check("req_cycle_after_capture", 64'(bus.mem_req_valid_o), 64'd1);
      repeat (3) tick();
      check("stall_valid_held", 64'(bus.mem_req_valid_o), 64'd1);
      check("stall_addr", 64'(bus.mem_addr_o), 64'h900);
      check("stall_strb", 64'(bus.mem_strb_o), 64'hFF);
      check("stall_wdata", bus.mem_wdata_o, DATA_BASE);
      check("stall_no_gnt", 64'(bus.op_gnt_o), 64'd0);
      bus.mem_req_ready_i = 1'b1;
      #1;
      check("gnt_same_cycle", 64'(bus.op_gnt_o), 64'd1);
      wait_done(seen);
      check("stall_done_seen", 64'(seen), 64'd1);
      check("stall_beats", 64'(beats), 64'd2);
      grant_done();

      // reset in the middle of a command after 2 of 4 beats
      rsp_en = 1'b0;
      start_cmd(32'hA00, 16'd32, 4'd12);
      bus.mem_req_ready_i = 1'b1;
      tick();
      bus.req_valid_i = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (beats >= 2) break;
         tick();
      end
      bus.mem_req_ready_i = 1'b0;
      check("midrst_two_beats", 64'(beats), 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_req_ready", 64'(bus.req_ready_o), 64'd1);
      check("midrst_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
      drops = 0;
      repeat (3) begin
         if (bus.done_o !== 1'b0) drops++;
         tick();
      end
      check("midrst_no_done", 64'(drops), 64'd0);
      stale_rsp = 1'b1;
      tick();
      stale_rsp = 1'b0;
      tick();
      run_cmd(32'hB00, 16'd16, 4'd7, 8'h00, seen, derr, did, rsp_ok);
      check("after_rst_done_seen", 64'(seen), 64'd1);
      check("after_rst_beats", 64'(beats), 64'd2);
      check("after_rst_done_id", 64'(did), 64'd7);
      check("after_rst_done_err", 64'(derr), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
